// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - passive VGA timing monitor: coordinate recovery, lock tracking, sticky timing errors
module vga_sync_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_clk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic        err_clr,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic        locked,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic [3:0]  err_flags
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [19:0] F_TOTAL_W = 20'(H_TOTAL * V_TOTAL);
  localparam logic [7:0]  HS_WIDTH_W = 8'(H_SYNC);
  localparam logic [9:0]  H_OFS = 10'(H_SYNC + H_BP);
  localparam logic [10:0] H_END = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_OFS = 10'(V_SYNC + V_BP);
  localparam logic [10:0] V_END = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic        ASSERTED = 1'(SYNC_POL);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        vclk_q, hs_q, vs_q;
  logic        tick, hs_a, vs_a, hs_rise, hs_fall, vs_rise;
  logic [9:0]  h_cnt, v_line, h_nxt, v_nxt;
  logic [7:0]  hs_w;
  logic [18:0] f_ticks;
  logic        h_seen, frame_err;
  logic        col_vis, row_vis, pix_vis;
  logic [9:0]  x_off, y_off;
  logic        ev_h, ev_v, ev_hs, ev_b, ev_track;
  logic [3:0]  ev_vec;

  // Decode ticks and sync edges, compute the coordinate of the sampled pixel and the error events
  always_comb begin
    tick    = vga_clk & ~vclk_q;
    hs_a    = (hsync == ASSERTED);
    vs_a    = (vsync == ASSERTED);
    hs_rise = tick & hs_a & ~hs_q;
    hs_fall = tick & ~hs_a & hs_q;
    vs_rise = tick & vs_a & ~vs_q;

    h_nxt = hs_rise ? 10'd0 : ((&h_cnt) ? h_cnt : h_cnt + 10'd1);
    if (vs_rise)
      v_nxt = 10'd0;
    else if (hs_rise && !(&v_line))
      v_nxt = v_line + 10'd1;
    else
      v_nxt = v_line;

    col_vis = (h_nxt >= H_OFS) && ({1'b0, h_nxt} < H_END);
    row_vis = (v_nxt >= V_OFS) && ({1'b0, v_nxt} < V_END);
    pix_vis = col_vis && row_vis;
    x_off   = h_nxt - H_OFS;
    y_off   = v_nxt - V_OFS;

    ev_h  = (state != SEARCH) && hs_rise && h_seen && (({1'b0, h_cnt} + 11'd1) != H_TOTAL_W);
    ev_v  = (state != SEARCH) && vs_rise && (({1'b0, f_ticks} + 20'd1) != F_TOTAL_W);
    ev_hs = (state != SEARCH) && hs_fall && h_seen && (hs_w != HS_WIDTH_W);
    ev_b  = (state == LOCKED) && tick && (blank_n != pix_vis);
    ev_track = ev_h | ev_v | ev_hs;
    ev_vec   = {ev_hs, ev_b, ev_v, ev_h};
  end

  // Lock FSM next-state: one clean frame between two vsync edges earns lock, any error drops it
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_rise) state_nxt = MEASURE;
      MEASURE: if (vs_rise && !frame_err && !ev_track) state_nxt = LOCKED;
      LOCKED:  if (ev_track || ev_b) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // Pixel-clock history and sync levels as seen at the previous tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vclk_q <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      vclk_q <= vga_clk;
      if (tick) begin
        hs_q <= hs_a;
        vs_q <= vs_a;
      end
    end
  end

  // Position, pulse-width and frame-length counters, advanced only on ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt   <= '0;
      v_line  <= '0;
      hs_w    <= '0;
      f_ticks <= '0;
    end else if (tick) begin
      h_cnt  <= h_nxt;
      v_line <= v_nxt;
      if (vs_rise)
        f_ticks <= '0;
      else if (!(&f_ticks))
        f_ticks <= f_ticks + 19'd1;
      if (!hs_a)
        hs_w <= '0;
      else if (hs_rise)
        hs_w <= 8'd1;
      else if (!(&hs_w))
        hs_w <= hs_w + 8'd1;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  // Measurement validity: a line is only judged once its start was seen, frame errors tracked per MEASURE frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_seen    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (state_nxt == SEARCH && state != SEARCH)
        h_seen <= 1'b0;
      else if (hs_rise)
        h_seen <= 1'b1;
      if (state != MEASURE || vs_rise)
        frame_err <= 1'b0;
      else if (ev_track)
        frame_err <= 1'b1;
    end
  end

  // Registered outputs: coordinates per tick, frame pulse/count while locked, sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_x        <= '0;
      rx_y        <= '0;
      rx_active   <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      err_flags   <= '0;
    end else begin
      frame_start <= (state == LOCKED) && vs_rise;
      if ((state == LOCKED) && vs_rise)
        frame_count <= frame_count + 16'd1;
      err_flags <= (err_clr ? 4'b0000 : err_flags) | ev_vec;
      if (tick) begin
        rx_x      <= pix_vis ? x_off : 10'd0;
        rx_y      <= pix_vis ? y_off : 10'd0;
        rx_active <= pix_vis && (state_nxt == LOCKED);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed self-checking bench for vga_sync_monitor on a reduced raster
module tb_vga_sync_monitor;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = 15;
  localparam int V_TOTAL  = 9;
  localparam int H_VS     = 5;
  localparam int H_VE     = 13;
  localparam int V_VS     = 4;
  localparam int V_VE     = 8;

  logic        clk = 1'b0;
  logic        rst, vga_clk, hsync, vsync, blank_n, err_clr;
  logic [9:0]  rx_x, rx_y;
  logic        rx_active, locked, frame_start;
  logic [15:0] frame_count;
  logic [3:0]  err_flags;

  int n_assert = 0;
  int n_fail   = 0;

  logic       s_lock [V_TOTAL][H_TOTAL+1];
  logic [3:0] s_err  [V_TOTAL][H_TOTAL+1];
  logic [9:0] s_x    [V_TOTAL][H_TOTAL+1];
  logic [9:0] s_y    [V_TOTAL][H_TOTAL+1];
  logic       s_act  [V_TOTAL][H_TOTAL+1];
  logic       s_fs   [V_TOTAL][H_TOTAL+1];

  vga_sync_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .err_clr(err_clr), .rx_x(rx_x), .rx_y(rx_y),
    .rx_active(rx_active), .locked(locked), .frame_start(frame_start),
    .frame_count(frame_count), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel: levels (asserted = 1) presented with a rising vga_clk, outputs settled on return
  task automatic pix(input logic hs, input logic vs, input logic bl, input logic clr);
    @(negedge clk);
    hsync   = ~hs;
    vsync   = ~vs;
    blank_n = bl;
    err_clr = clr;
    vga_clk = 1'b1;
    @(negedge clk);
    vga_clk = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic frame(input int l0, input int l1, input int stretch_l, input int short_l,
                       input int kill_l, input int kill_p, input logic clr_fall);
    logic hs, vs, bl, clr;
    for (int l = l0; l < l1; l++) begin
      for (int p = 0; p < H_TOTAL + ((l == stretch_l) ? 1 : 0); p++) begin
        hs  = (p < H_SYNC) && !((l == short_l) && (p == H_SYNC - 1));
        vs  = (l < V_SYNC);
        bl  = (p >= H_VS) && (p < H_VE) && (l >= V_VS) && (l < V_VE) && !((l == kill_l) && (p == kill_p));
        clr = clr_fall && (l == short_l) && (p == H_SYNC - 1);
        pix(hs, vs, bl, clr);
        s_lock[l][p] = locked;
        s_err[l][p]  = err_flags;
        s_x[l][p]    = rx_x;
        s_y[l][p]    = rx_y;
        s_act[l][p]  = rx_active;
        s_fs[l][p]   = frame_start;
      end
    end
  endtask

  task automatic nom();
    frame(0, V_TOTAL, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vga_clk = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_active", 32'(rx_active), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_rx_x", 32'(rx_x), 32'd0);
    chk("rst_rx_y", 32'(rx_y), 32'd0);
    rst = 1'b0;

    // First vsync only starts measurement; lock at the second
    nom();
    chk("f1_not_locked_start", 32'(s_lock[0][0]), 32'd0);
    chk("f1_not_locked_end", 32'(s_lock[V_TOTAL-1][H_TOTAL-1]), 32'd0);
    nom();
    chk("f2_locked", 32'(s_lock[0][0]), 32'd1);
    chk("f2_no_fstart_on_lock", 32'(s_fs[0][0]), 32'd0);
    chk("first_px_x", 32'(s_x[V_VS][H_VS]), 32'd0);
    chk("first_px_y", 32'(s_y[V_VS][H_VS]), 32'd0);
    chk("first_px_act", 32'(s_act[V_VS][H_VS]), 32'd1);
    chk("last_px_x", 32'(s_x[V_VE-1][H_VE-1]), 32'd7);
    chk("last_px_y", 32'(s_y[V_VE-1][H_VE-1]), 32'd3);
    chk("last_px_act", 32'(s_act[V_VE-1][H_VE-1]), 32'd1);
    chk("past_col_act", 32'(s_act[V_VE-1][H_VE]), 32'd0);
    chk("past_col_x", 32'(s_x[V_VE-1][H_VE]), 32'd0);
    chk("pre_row_act", 32'(s_act[V_VS-1][H_VS]), 32'd0);
    chk("mid_px_x", 32'(s_x[5][9]), 32'd4);
    chk("mid_px_y", 32'(s_y[5][9]), 32'd1);
    chk("f2_err", 32'(err_flags), 32'd0);
    chk("f2_fcount", 32'(frame_count), 32'd0);

    nom();
    chk("f3_fstart", 32'(s_fs[0][0]), 32'd1);
    chk("f3_fstart_one_clk", 32'(s_fs[0][1]), 32'd0);
    nom();
    nom();
    chk("fcount_3", 32'(frame_count), 32'd3);
    chk("nominal_err", 32'(err_flags), 32'd0);

    // Line 6 stretched by one tick: H_LEN at the next hsync edge
    frame(0, V_TOTAL, 6, -1, -1, -1, 1'b0);
    chk("hlen_locked_before", 32'(s_lock[6][H_TOTAL]), 32'd1);
    chk("hlen_err", 32'(s_err[7][0]), 32'd1);
    chk("hlen_unlock", 32'(s_lock[7][0]), 32'd0);
    nom();
    chk("hlen_measure", 32'(s_lock[0][0]), 32'd0);
    nom();
    chk("hlen_relock", 32'(s_lock[0][0]), 32'd1);
    chk("hlen_err_sticky", 32'(err_flags), 32'd1);
    clr_pulse();
    chk("clr_after_hlen", 32'(err_flags), 32'd0);

    // Short hsync pulse while locked
    frame(0, V_TOTAL, -1, 3, -1, -1, 1'b0);
    chk("hsw_err", 32'(s_err[3][H_SYNC-1]), 32'd8);
    chk("hsw_unlock", 32'(s_lock[3][H_SYNC-1]), 32'd0);
    clr_pulse();
    chk("clr_after_hsw", 32'(err_flags), 32'd0);

    // Short pulse during MEASURE with err_clr on the same tick; the frame then fails to lock
    frame(0, V_TOTAL, -1, 3, -1, -1, 1'b1);
    chk("hsw_clr_same_cycle", 32'(s_err[3][H_SYNC-1]), 32'd8);
    chk("hsw_measure_unlocked", 32'(s_lock[3][H_SYNC-1]), 32'd0);
    nom();
    chk("measure_restart", 32'(s_lock[0][0]), 32'd0);
    nom();
    chk("measure_relock", 32'(s_lock[0][0]), 32'd1);
    chk("hsw_err_sticky", 32'(err_flags), 32'd8);
    clr_pulse();

    // blank_n dropped at a visible pixel
    frame(0, V_TOTAL, -1, -1, 6, 7, 1'b0);
    chk("blank_prev_act", 32'(s_act[6][6]), 32'd1);
    chk("blank_prev_x", 32'(s_x[6][6]), 32'd1);
    chk("blank_prev_y", 32'(s_y[6][6]), 32'd2);
    chk("blank_err", 32'(s_err[6][7]), 32'd4);
    chk("blank_unlock", 32'(s_lock[6][7]), 32'd0);
    chk("blank_act", 32'(s_act[6][7]), 32'd0);

    // Relock, then reset in the middle of a frame
    nom();
    nom();
    frame(0, 4, -1, -1, -1, -1, 1'b0);
    chk("pre_reset_locked", 32'(s_lock[3][H_TOTAL-1]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_err", 32'(err_flags), 32'd0);
    chk("async_rst_fcount", 32'(frame_count), 32'd0);
    chk("async_rst_act", 32'(rx_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(4, V_TOTAL, -1, -1, -1, -1, 1'b0);
    nom();
    chk("post_rst_measure", 32'(s_lock[0][0]), 32'd0);
    nom();
    chk("post_rst_relock", 32'(s_lock[0][0]), 32'd1);
    chk("post_rst_fcount0", 32'(frame_count), 32'd0);
    nom();
    chk("post_rst_fcount1", 32'(frame_count), 32'd1);
    chk("post_rst_err", 32'(err_flags), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Passive sink for the VGA timing produced by the VGA driver. It samples `vga_clk`, `hsync`, `vsync` and `VGA_BLANK_N` in the 50 MHz system domain and recovers the pixel coordinate being scanned. It measures line, frame and sync-pulse lengths, declares lock after one fully correct frame, and reports sticky timing errors. It sits beside the driver on the same wires, for on-board self-check and for closed-loop simulation benches.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  50 MHz system clock (CLOCK_50)
- rst  in  1  reset, asynchronous, active-high
- vga_clk  in  1  pixel clock from the driver; synchronous to clk, clk/2
- hsync  in  1  horizontal sync from the driver
- vsync  in  1  vertical sync from the driver
- blank_n  in  1  driver blank (1 = visible)
- err_clr  in  1  one-cycle pulse; clears err_flags
- rx_x  out  10  recovered column, 0..H_ACTIVE-1; 0 outside active
- rx_y  out  10  recovered row, 0..V_ACTIVE-1; 0 outside active
- rx_active  out  1  locked and sampled pixel is visible
- locked  out  1  timing lock achieved
- frame_start  out  1  one-clk pulse on vsync assertion while locked
- frame_count  out  16  frames seen while locked, wraps
- err_flags  out  4  sticky: [0] H_LEN, [1] V_LEN, [2] BLANK, [3] HS_WIDTH

## Operation
- Pixel tick: `vga_clk` is registered. tick = (prev 0, now 1). All counters advance only on tick cycles.
- Edges: hsync and vsync are normalised by SYNC_POL, then compared with their values at the previous tick. An assertion edge is a change from inactive to asserted.
- h_cnt (10 b):
  - Set to 0 on an hsync assertion tick; otherwise +1 per tick, saturating at 1023.
  - On an hsync assertion tick, if a prior assertion has been seen since reset or SEARCH entry: if h_cnt+1 != H_TOTAL (800), set H_LEN.
- hs_w (8 b):
  - Counts ticks while hsync is asserted.
  - On the deassertion tick, if hs_w != H_SYNC, set HS_WIDTH.
- v_line (10 b):
  - Set to 0 on a vsync assertion tick.
  - Otherwise +1 on each hsync assertion tick.
  - The vsync assertion edge takes precedence when both edges land on the same tick.
- f_ticks (19 b):
  - Ticks since the last vsync assertion.
  - On a vsync assertion tick, if f_ticks+1 != H_TOTAL*V_TOTAL (420000), set V_LEN.
  - Then set f_ticks to 0.
- Visibility:
  - Column visible when h_cnt ∈ [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), i.e. [144, 784).
  - Row visible when v_line ∈ [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), i.e. [35, 515).
  - rx_x = h_cnt-144 and rx_y = v_line-35 when both are visible; otherwise both are 0.
- BLANK check: only in LOCKED. On each tick, if blank_n != (column visible && row visible), set BLANK.
- FSM:
  - SEARCH: wait for a vsync assertion tick, then go to MEASURE. Errors are ignored here and the measure-valid flags are cleared on entry.
  - MEASURE: at the next vsync assertion tick, go to LOCKED if no H_LEN, V_LEN or HS_WIDTH event occurred in this frame. Otherwise stay in MEASURE and restart the per-frame error tracking.
  - LOCKED: any new H_LEN, V_LEN, HS_WIDTH or BLANK event goes to SEARCH on the next clk.
- locked = (state == LOCKED).
- In LOCKED, each vsync assertion tick pulses frame_start and increments frame_count (0xFFFF wraps to 0). The tick that causes the MEASURE to LOCKED transition does neither.
- err_flags:
  - Set only by events in MEASURE or LOCKED.
  - Cleared by rst or err_clr.
  - If err_clr and a new error event occur in the same cycle, the new event wins and its bit reads 1.

## Timing
- Reset values: rx_x = 0, rx_y = 0, rx_active = 0, locked = 0, frame_start = 0, frame_count = 0, err_flags = 0, state = SEARCH, all counters 0.
- Async assert; rst low releases on the next clk edge.
- All outputs are registered. Outputs for the pixel sampled at tick cycle T are valid at T+1 and held until the next tick update.
- frame_start is high exactly one clk, at T+1.
- locked rises at T+1 after the qualifying vsync tick and falls at T+1 after an error tick.
- Lock requires at least one full frame after the first vsync edge: about 2 frames (33.6 ms) from reset.
- Reset mid-frame: restart in SEARCH. No error is raised for the partial line or frame.
- vga_clk stopped: no ticks, outputs hold, no timeout. Stall detection is out of scope.

## Test plan
- Nominal 640×480 driver stimulus from reset -> locked rises at the 2nd vsync assertion +1 clk; err_flags = 0; frame_count = 3 after 3 further frames.
- Locked, pixel at h_cnt = 144, v_line = 35 -> rx_x = 0, rx_y = 0, rx_active = 1. At h_cnt = 783, v_line = 514 -> rx_x = 639, rx_y = 479. At h_cnt = 784 -> rx_active = 0.
- Locked, one line stretched to 801 ticks -> err_flags[0] = 1, locked = 0 next clk, relock after two clean vsyncs.
- Locked, hsync pulse 95 ticks -> err_flags[3] = 1. err_clr pulse -> err_flags = 0. Error on the same cycle as err_clr -> bit stays 1.
- Locked, blank_n forced 0 at pixel (10, 10) -> err_flags[2] = 1, locked = 0.
- rst asserted mid-frame while locked -> all outputs 0 immediately (async). After release, relock within 2 frames; frame_count restarts at 0.
